fir_seq_ctrl: RTL
=================

# fir_seq_ctrl

Sequencing controller for the FIR filter datapath. It owns the filter's synchronous reset and enable, paces samples with a programmable clock-enable divider, and gates the output-valid flag until the delay line has filled. It also reloads the coefficient bank via a valid/ready handshake. It sits between the system control/CPU-side register logic and the FIR instance.

## Interface
- NB_COEFF, 8: coefficient word width.
- N_TAPS, 4: number of coefficients (≥2).
- NB_DIV, 8: width of the sample-rate divider.
- FLUSH_CYCLES, 4: clocks the FIR synchronous reset is held in FLUSH (≥1).
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  level; leave IDLE and start filtering.
- i_stop  in  1  level; return to IDLE.
- i_div  in  NB_DIV  sample period minus 1 (0 = every clock).
- i_coef_valid  in  1  coefficient word available.
- i_coef_data  in  NB_COEFF  coefficient word.
- o_coef_ready  out  1  controller accepts a coefficient word.
- o_coef_we  out  1  coefficient write strobe to the FIR bank.
- o_coef_addr  out  $clog2(N_TAPS)  tap index for o_coef_we.
- o_coef_data  out  NB_COEFF  coefficient written.
- o_fir_srst  out  1  drives the FIR i_srst.
- o_fir_en  out  1  drives the FIR i_en (one-clock sample strobe).
- o_os_valid  out  1  FIR o_os_data is a valid filtered sample this cycle.
- o_state  out  3  current state encoding (IDLE=0, FLUSH=1, FILL=2, RUN=3, LOAD=4).

## Operation
- All outputs are registered. Priority of requests, highest first: i_stop, i_coef_valid, i_start.
- IDLE: o_fir_srst=1, o_fir_en=0.
  - i_coef_valid goes to LOAD.
  - Otherwise i_start goes to FLUSH.
- FLUSH: o_fir_srst=1 for exactly FLUSH_CYCLES clocks, then FILL. i_div is latched into div_q on exit.
- FILL and RUN share a divider counter. It issues an o_fir_en pulse on the first FILL cycle and every div_q+1 clocks after that.
  - FILL issues N_TAPS-1 strobes and then enters RUN.
  - Changes to i_div are ignored until the next FLUSH.
- RUN: strobes continue. o_os_valid pulses exactly one clock after every RUN strobe.
  - i_coef_valid goes to LOAD.
  - i_stop goes to IDLE.
  - i_start has no effect.
- LOAD: o_fir_en=0, o_fir_srst=0, o_coef_ready=1.
  - A word transfers on i_coef_valid & o_coef_ready. The next clock sets o_coef_we=1 with o_coef_addr = tap counter (0..N_TAPS-1) and o_coef_data = the captured word.
  - After word N_TAPS-1 the state goes to FLUSH, because the delay line holds samples filtered with stale coefficients. o_coef_ready drops in the same cycle the last word is accepted.
  - i_stop in LOAD aborts to IDLE. The tap counter clears and taps already written keep their new values.
- Reset mid-operation (i_rst_n low) immediately forces IDLE, clears all counters and restores the reset values below.

## Timing
- Reset values: o_fir_srst=1; o_fir_en, o_os_valid, o_coef_ready, o_coef_we = 0; o_coef_addr=0; o_coef_data=0; o_state=IDLE.
- Cycle t samples i_start in IDLE. FLUSH runs from t+1 to t+FLUSH_CYCLES. o_fir_srst falls at t+FLUSH_CYCLES+1, which is also the first FILL cycle and carries the first o_fir_en.
- Strobe k (k≥0) falls at t+FLUSH_CYCLES+1+k·(div_q+1). Strobe N_TAPS-1 is the first RUN strobe. Its o_os_valid comes one clock later.
- i_stop sampled at cycle s: o_fir_en and o_os_valid are 0 from s+1 onward, and o_fir_srst=1 from s+1.
- Coefficient latency: accept at cycle a, o_coef_we at a+1. Back-to-back accepts are allowed, one word per clock.
- A strobe never coincides with o_fir_srst=1 or with o_coef_we=1.

## Configuration
- FIR_SEQ_COEF_LOAD_EN defined: the LOAD state and the coefficient handshake are present as described.
- Undefined: LOAD is removed.
  - o_coef_ready, o_coef_we, o_coef_addr and o_coef_data are tied to 0.
  - i_coef_valid and i_coef_data are ignored.
  - State encoding 4 is unused.

## Test plan
- Reset and start, with N_TAPS=4, FLUSH_CYCLES=4, i_div=0, i_start at cycle 10:
  - o_fir_srst is high for cycles 11–14.
  - o_fir_en is high every clock from cycle 15.
  - o_os_valid is first high at cycle 19 and continuous after that.
- Divided rate, i_div=24: strobes are 25 clocks apart. o_os_valid is one clock after each strobe from the 4th strobe on. Changing i_div to 3 in RUN leaves the spacing at 25.
- Coefficient load from RUN: 4 back-to-back words 0x80, 0x40, 0xE0, 0x10.
  - o_coef_we is seen 4 times with addresses 0..3 and the same data, no o_fir_en during the load.
  - The controller then passes through FLUSH for 4 clocks and FILL before o_os_valid resumes.
- Stop in LOAD after 2 words: state goes to IDLE the next clock. A following load starts again at address 0.
- Simultaneous events: i_stop, i_start and i_coef_valid all high in RUN gives IDLE. i_coef_valid with i_start in IDLE gives LOAD.
- Asynchronous reset asserted mid-RUN between clock edges: all outputs take reset values immediately, without waiting for a clock edge. With the macro undefined, i_coef_valid=1 in RUN leaves o_coef_ready=0 and the state stays RUN.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: flush, paced fill/run strobes, output-valid gating and coefficient reload.
// The LOAD state and coefficient handshake exist only when FIR_SEQ_COEF_LOAD_EN is defined.
module fir_seq_ctrl #(
    parameter int NB_COEFF     = 8,
    parameter int N_TAPS       = 4,
    parameter int NB_DIV       = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [NB_DIV-1:0]         i_div,
    input  logic                      i_coef_valid,
    input  logic [NB_COEFF-1:0]       i_coef_data,
    output logic                      o_coef_ready,
    output logic                      o_coef_we,
    output logic [$clog2(N_TAPS)-1:0] o_coef_addr,
    output logic [NB_COEFF-1:0]       o_coef_data,
    output logic                      o_fir_srst,
    output logic                      o_fir_en,
    output logic                      o_os_valid,
    output logic [2:0]                o_state
);
    localparam int NB_TAP   = $clog2(N_TAPS);
    localparam int NB_FLUSH = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [NB_TAP-1:0]   TAP_LAST   = NB_TAP'(N_TAPS - 1);
    localparam logic [NB_FLUSH-1:0] FLUSH_LAST = NB_FLUSH'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NB_FLUSH-1:0] r_flush_cnt;
    logic [NB_FLUSH-1:0] w_flush_cnt_nxt;
    logic [NB_DIV-1:0]   r_div_q;
    logic [NB_DIV-1:0]   r_div_cnt;
    logic [NB_DIV-1:0]   w_div_cnt_nxt;
    logic [NB_TAP-1:0]   r_fill_cnt;
    logic [NB_TAP-1:0]   w_fill_cnt_nxt;
    logic                r_fir_srst;
    logic                r_fir_en;
    logic                w_fir_en_nxt;
    logic                r_os_valid;
    logic                w_os_valid_nxt;
    logic                w_flush_exit;
    logic                w_coef_req;
    logic                w_load_done;

    // Request priority is stop, then coefficient reload, then start.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_stop)          w_state_nxt = ST_IDLE;
                else if (w_coef_req) w_state_nxt = ST_LOAD;
                else if (i_start)    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (i_stop)                          w_state_nxt = ST_IDLE;
                else if (r_flush_cnt == FLUSH_LAST)  w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (i_stop)                    w_state_nxt = ST_IDLE;
                else if (r_fill_cnt == TAP_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_stop)          w_state_nxt = ST_IDLE;
                else if (w_coef_req) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (i_stop)           w_state_nxt = ST_IDLE;
                else if (w_load_done) w_state_nxt = ST_FLUSH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_flush_exit = (r_state == ST_FLUSH) && (w_state_nxt == ST_FILL);

    // The divider counts clocks since the last strobe; the first FILL cycle always strobes.
    always_comb begin
        w_fir_en_nxt  = 1'b0;
        w_div_cnt_nxt = '0;
        if (w_flush_exit) begin
            w_fir_en_nxt = 1'b1;
        end else if (w_state_nxt == ST_FILL || w_state_nxt == ST_RUN) begin
            if (r_div_cnt == r_div_q) w_fir_en_nxt  = 1'b1;
            else                      w_div_cnt_nxt = r_div_cnt + NB_DIV'(1);
        end
    end

    always_comb begin
        w_flush_cnt_nxt = '0;
        w_fill_cnt_nxt  = '0;
        if (r_state == ST_FLUSH && w_state_nxt == ST_FLUSH)
            w_flush_cnt_nxt = r_flush_cnt + NB_FLUSH'(1);
        if (w_state_nxt == ST_FILL)
            w_fill_cnt_nxt = r_fill_cnt + NB_TAP'(w_fir_en_nxt);
    end

    // A RUN strobe yields a valid sample next clock unless the same edge returns to IDLE.
    assign w_os_valid_nxt = r_fir_en && (r_state == ST_RUN) && (w_state_nxt != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_div_q     <= '0;
            r_div_cnt   <= '0;
            r_fill_cnt  <= '0;
            r_fir_srst  <= 1'b1;
            r_fir_en    <= 1'b0;
            r_os_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_fir_srst  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FLUSH);
            r_fir_en    <= w_fir_en_nxt;
            r_os_valid  <= w_os_valid_nxt;
            if (w_flush_exit)
                r_div_q <= i_div;
        end
    end

    assign o_fir_srst = r_fir_srst;
    assign o_fir_en   = r_fir_en;
    assign o_os_valid = r_os_valid;
    assign o_state    = r_state;

`ifdef FIR_SEQ_COEF_LOAD_EN
    logic                r_coef_ready;
    logic                r_coef_we;
    logic [NB_TAP-1:0]   r_coef_addr;
    logic [NB_COEFF-1:0] r_coef_data;
    logic [NB_TAP-1:0]   r_tap_cnt;
    logic                w_coef_acc;

    assign w_coef_req  = i_coef_valid;
    assign w_coef_acc  = (r_state == ST_LOAD) && r_coef_ready && i_coef_valid;
    assign w_load_done = w_coef_acc && (r_tap_cnt == TAP_LAST);

    // Ready follows the next state, so it drops on the edge that accepts the last word.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coef_ready <= 1'b0;
            r_coef_we    <= 1'b0;
            r_coef_addr  <= '0;
            r_coef_data  <= '0;
            r_tap_cnt    <= '0;
        end else begin
            r_coef_ready <= (w_state_nxt == ST_LOAD);
            r_coef_we    <= w_coef_acc;
            if (w_coef_acc) begin
                r_coef_addr <= r_tap_cnt;
                r_coef_data <= i_coef_data;
            end
            if (w_state_nxt != ST_LOAD)
                r_tap_cnt <= '0;
            else if (w_coef_acc)
                r_tap_cnt <= r_tap_cnt + NB_TAP'(1);
        end
    end

    assign o_coef_ready = r_coef_ready;
    assign o_coef_we    = r_coef_we;
    assign o_coef_addr  = r_coef_addr;
    assign o_coef_data  = r_coef_data;
`else
    logic w_unused_coef;

    assign w_coef_req    = 1'b0;
    assign w_load_done   = 1'b0;
    assign w_unused_coef = ^{i_coef_valid, i_coef_data};
    assign o_coef_ready  = 1'b0;
    assign o_coef_we     = 1'b0;
    assign o_coef_addr   = '0;
    assign o_coef_data   = '0;
`endif

endmodule
